// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with busy-bit scoreboard.
package regfile_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int REG_ZERO       = 0;

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction
endpackage

// File: rtl/regfile_scoreboard_bits.sv
// Busy-bit scoreboard: per-register pending flags, running pending count, sticky hazard flags.
module scoreboard_bits
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                       clock,
    input  logic                       ctrl_reset,
    input  logic                       set_en_i,
    input  logic [ADDR_WIDTH-1:0]      set_idx_i,
    input  logic                       clr_en_i,
    input  logic [ADDR_WIDTH-1:0]      clr_idx_i,
    output logic [depth(ADDR_WIDTH)-1:0] busy_o,
    output logic [ADDR_WIDTH:0]        pending_count_o,
    output logic                       err_waw_o,
    output logic                       err_stale_o
);
    localparam int DEPTH = depth(ADDR_WIDTH);
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [CW-1:0]    count_q, count_d;
    logic             waw_q, waw_d, stale_q, stale_d;
    logic             same, inc, dec;

    always_comb begin
        busy_d = busy_q;
        // Issue applied after writeback so a back-to-back producer keeps the bit set.
        if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
        if (set_en_i) busy_d[set_idx_i] = 1'b1;
        same    = set_en_i && clr_en_i && (set_idx_i == clr_idx_i);
        inc     = set_en_i && !busy_q[set_idx_i];
        dec     = clr_en_i && busy_q[clr_idx_i] && !same;
        count_d = count_q + CW'(inc) - CW'(dec);
        waw_d   = waw_q | (set_en_i && busy_q[set_idx_i] && !same);
        stale_d = stale_q | (clr_en_i && !busy_q[clr_idx_i]);
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            busy_q  <= '0;
            count_q <= '0;
            waw_q   <= 1'b0;
            stale_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            waw_q   <= waw_d;
            stale_q <= stale_d;
        end
    end

    assign busy_o          = busy_q;
    assign pending_count_o = count_q;
    assign err_waw_o       = waw_q;
    assign err_stale_o     = stale_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with optional bypass and zero register, plus busy scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEn,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic                  ctrl_issueEn,
    input  logic [ADDR_WIDTH-1:0] ctrl_issueReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    output logic                  busy_readRegA,
    output logic                  busy_readRegB,
    output logic [ADDR_WIDTH:0]   pending_count,
    output logic                  err_waw,
    output logic                  err_stale
);
    localparam int DEPTH = depth(ADDR_WIDTH);

    function automatic logic writable(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG == 0) || (a != ADDR_WIDTH'(REG_ZERO));
    endfunction

    logic [DATA_WIDTH-1:0]            regs_q [DEPTH];
    logic [DEPTH-1:0]                 busy;
    logic                             wr_ok, iss_ok;
    logic [1:0][ADDR_WIDTH-1:0]       raddr;
    logic [1:0][DATA_WIDTH-1:0]       rdata;
    logic [1:0]                       rbusy;

    assign wr_ok  = ctrl_writeEn && writable(ctrl_writeReg);
    assign iss_ok = ctrl_issueEn && writable(ctrl_issueReg);

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wr_ok) begin
            regs_q[ctrl_writeReg] <= data_writeReg;
        end
    end

    scoreboard_bits #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
        .clock           (clock),
        .ctrl_reset      (ctrl_reset),
        .set_en_i        (iss_ok),
        .set_idx_i       (ctrl_issueReg),
        .clr_en_i        (wr_ok),
        .clr_idx_i       (ctrl_writeReg),
        .busy_o          (busy),
        .pending_count_o (pending_count),
        .err_waw_o       (err_waw),
        .err_stale_o     (err_stale)
    );

    assign raddr[0] = ctrl_readRegA;
    assign raddr[1] = ctrl_readRegB;

    // Reset gates the read ports so the bypass path cannot leak write data.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int p = 0; p < 2; p++) begin
            if (ctrl_reset && writable(raddr[p])) begin
                if ((BYPASS != 0) && wr_ok && (ctrl_writeReg == raddr[p])) begin
                    rdata[p] = data_writeReg;
                end else begin
                    rdata[p] = regs_q[raddr[p]];
                    rbusy[p] = busy[raddr[p]];
                end
            end
        end
    end

    assign data_readRegA = rdata[0];
    assign data_readRegB = rdata[1];
    assign busy_readRegA = rbusy[0];
    assign busy_readRegB = rbusy[1];
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with default parameters (32x32, zero reg, bypass).
module tb_regfile_scoreboard;
    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        ctrl_writeEn, ctrl_issueEn;
    logic [4:0]  ctrl_writeReg, ctrl_issueReg, ctrl_readRegA, ctrl_readRegB;
    logic [31:0] data_writeReg, data_readRegA, data_readRegB;
    logic        busy_readRegA, busy_readRegB, err_waw, err_stale;
    logic [5:0]  pending_count;

    int checks = 0;
    int failures = 0;

    regfile_scoreboard dut (
        .clock         (clock),
        .ctrl_reset    (ctrl_reset),
        .ctrl_writeEn  (ctrl_writeEn),
        .ctrl_writeReg (ctrl_writeReg),
        .data_writeReg (data_writeReg),
        .ctrl_issueEn  (ctrl_issueEn),
        .ctrl_issueReg (ctrl_issueReg),
        .ctrl_readRegA (ctrl_readRegA),
        .ctrl_readRegB (ctrl_readRegB),
        .data_readRegA (data_readRegA),
        .data_readRegB (data_readRegB),
        .busy_readRegA (busy_readRegA),
        .busy_readRegB (busy_readRegB),
        .pending_count (pending_count),
        .err_waw       (err_waw),
        .err_stale     (err_stale)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ctrl_writeEn = 1'b0;
        ctrl_issueEn = 1'b0;
    endtask

    initial begin
        ctrl_reset = 1'b0;
        idle();
        ctrl_writeReg = '0; ctrl_issueReg = '0; data_writeReg = '0;
        ctrl_readRegA = 5'd1; ctrl_readRegB = 5'd2;
        #2;
        chk("rst_dataA", data_readRegA, 32'h0);
        chk("rst_count", 32'(pending_count), 32'd0);
        chk("rst_flags", {30'd0, err_waw, err_stale}, 32'd0);
        step();
        ctrl_reset = 1'b1;
        step();

        // 1: fill r1..r31 (issue then writeback so no stale flag), then try r0
        for (int i = 1; i < 32; i++) begin
            ctrl_issueEn = 1'b1; ctrl_issueReg = 5'(i);
            step();
            ctrl_issueEn = 1'b0;
            ctrl_writeEn = 1'b1; ctrl_writeReg = 5'(i); data_writeReg = 32'h0000DEAD;
            step();
            ctrl_writeEn = 1'b0;
        end
        ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'hFFFFFFFF;
        step();
        idle();
        chk("fill_count", 32'(pending_count), 32'd0);
        chk("fill_flags", {30'd0, err_waw, err_stale}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = 5'(i); ctrl_readRegB = 5'(31 - i);
            #1;
            chk($sformatf("fillA_r%0d", i), data_readRegA, (i == 0) ? 32'h0 : 32'h0000DEAD);
            chk($sformatf("fillB_r%0d", 31 - i), data_readRegB, (i == 31) ? 32'h0 : 32'h0000DEAD);
        end

        // 2: issue r5, then writeback with bypass
        ctrl_issueEn = 1'b1; ctrl_issueReg = 5'd5; ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd5;
        #1;
        chk("iss_same_cycle_busyA", 32'(busy_readRegA), 32'd0);
        step();
        idle();
        chk("iss_busyA", 32'(busy_readRegA), 32'd1);
        chk("iss_count", 32'(pending_count), 32'd1);
        ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'h12345678;
        #1;
        chk("byp_dataB", data_readRegB, 32'h12345678);
        chk("byp_busyB", 32'(busy_readRegB), 32'd0);
        step();
        idle();
        chk("wb_count", 32'(pending_count), 32'd0);
        chk("wb_dataA", data_readRegA, 32'h12345678);
        chk("wb_stale", 32'(err_stale), 32'd0);

        // 3: back-to-back producer on r7
        ctrl_issueEn = 1'b1; ctrl_issueReg = 5'd7;
        step();
        ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'h00000077;
        step();
        idle();
        ctrl_readRegA = 5'd7;
        #1;
        chk("b2b_busyA", 32'(busy_readRegA), 32'd1);
        chk("b2b_count", 32'(pending_count), 32'd1);
        chk("b2b_waw", 32'(err_waw), 32'd0);
        chk("b2b_data", data_readRegA, 32'h00000077);

        // 4: WAW on r3, stale writeback on r9
        ctrl_issueEn = 1'b1; ctrl_issueReg = 5'd3;
        step();
        chk("waw_first", 32'(err_waw), 32'd0);
        chk("waw_count", 32'(pending_count), 32'd2);
        step();
        idle();
        chk("waw_second", 32'(err_waw), 32'd1);
        step();
        chk("waw_sticky", 32'(err_waw), 32'd1);
        chk("stale_before", 32'(err_stale), 32'd0);
        ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'h00000099;
        step();
        idle();
        ctrl_readRegB = 5'd9;
        #1;
        chk("stale_set", 32'(err_stale), 32'd1);
        chk("stale_data", data_readRegB, 32'h00000099);
        chk("stale_count", 32'(pending_count), 32'd2);

        // 5: issue everything, count saturates at the writable depth
        for (int i = 0; i < 32; i++) begin
            ctrl_issueEn = 1'b1; ctrl_issueReg = 5'(i);
            step();
        end
        idle();
        chk("all_count", 32'(pending_count), 32'd31);
        ctrl_issueEn = 1'b1; ctrl_issueReg = 5'd0;
        step();
        idle();
        ctrl_readRegA = 5'd0;
        #1;
        chk("r0_count", 32'(pending_count), 32'd31);
        chk("r0_busy", 32'(busy_readRegA), 32'd0);

        // 6: asynchronous reset mid-cycle
        ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd4; data_writeReg = 32'hCAFEF00D;
        ctrl_issueEn = 1'b1; ctrl_issueReg = 5'd4;
        step();
        idle();
        ctrl_readRegA = 5'd4; ctrl_readRegB = 5'd7;
        #1;
        chk("pre_rst_data", data_readRegA, 32'hCAFEF00D);
        chk("pre_rst_busy", 32'(busy_readRegA), 32'd1);
        #1;
        ctrl_reset = 1'b0;
        #1;
        chk("rst_mid_dataA", data_readRegA, 32'h0);
        chk("rst_mid_dataB", data_readRegB, 32'h0);
        chk("rst_mid_count", 32'(pending_count), 32'd0);
        #2;
        ctrl_reset = 1'b1;
        step();
        chk("post_rst_busy", 32'(busy_readRegA), 32'd0);
        chk("post_rst_count", 32'(pending_count), 32'd0);
        chk("post_rst_flags", {30'd0, err_waw, err_stale}, 32'd0);
        chk("post_rst_data", data_readRegA, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
